// File: rtl/i2c_slave_regs.sv
// I2C target exposing a local register file: START/STOP decode, 7-bit address
// match, register-address byte, then auto-incrementing byte writes or reads.
`timescale 1ns/1ps
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oen,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // index 0 = SCL, 1 = SDA; all reset to the idle-bus level so reset release is quiet
  logic [1:0]         sync1_q, sync2_q, filt_q, prev_q;
  logic [1:0][CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {sda_in, scl_in};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0] byte_d;

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_p    = prev_q[0];
  assign sda_p    = prev_q[1];
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;

  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] shift_q, addr_q, wdata_q;
  logic       rw_q, oen_q, busy_q, wr_en_q, rd_en_q, ld_q;

  assign byte_d = {shift_q[6:0], sda_f};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      oen_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      // read data returns the cycle after the strobe; capture it one clk later
      ld_q    <= rd_en_q;
      if (ld_q) shift_q <= rd_data;

      if (stop_ev) begin
        state_q <= IDLE;
        oen_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_ev) begin
        state_q  <= DEV_ADDR;
        bitcnt_q <= '0;
        oen_q    <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          DEV_ADDR, REG_ADDR, WR_DATA: begin
            shift_q  <= byte_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              case (state_q)
                DEV_ADDR: begin
                  if (byte_d[7:1] == SLAVE_ADDR) begin
                    state_q <= DEV_ACK;
                    rw_q    <= byte_d[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= IGNORE;
                    busy_q  <= 1'b0;
                  end
                end
                REG_ADDR: begin
                  addr_q  <= byte_d;
                  state_q <= REG_ACK;
                end
                default: begin
                  wdata_q <= byte_d;
                  wr_en_q <= 1'b1;
                  state_q <= WR_ACK;
                end
              endcase
            end
          end
          // fetch on the 9th rise so the MSB is ready at the 9th fall
          DEV_ACK: if (rw_q && oen_q) rd_en_q <= 1'b1;
          RD_ACK: begin
            if (sda_f) begin
              state_q <= IGNORE;
              busy_q  <= 1'b0;
            end else begin
              addr_q  <= addr_q + 8'd1;
              rd_en_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          DEV_ACK: begin
            if (!oen_q) oen_q <= 1'b1;
            else if (rw_q) begin
              state_q  <= RD_DATA;
              oen_q    <= ~shift_q[7];
              bitcnt_q <= '0;
            end else begin
              state_q  <= REG_ADDR;
              oen_q    <= 1'b0;
              bitcnt_q <= '0;
            end
          end
          REG_ACK, WR_ACK: begin
            if (!oen_q) oen_q <= 1'b1;
            else begin
              if (state_q == WR_ACK) addr_q <= addr_q + 8'd1;
              state_q  <= WR_DATA;
              oen_q    <= 1'b0;
              bitcnt_q <= '0;
            end
          end
          RD_DATA: begin
            if (bitcnt_q == 3'd7) begin
              oen_q   <= 1'b0;
              state_q <= RD_ACK;
            end else begin
              shift_q  <= {shift_q[6:0], 1'b0};
              oen_q    <= ~shift_q[6];
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end
          RD_ACK: begin
            state_q  <= RD_DATA;
            oen_q    <= ~shift_q[7];
            bitcnt_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_out  = 1'b0;
  assign sda_oen  = oen_q;
  assign reg_addr = addr_q;
  assign wr_data  = wdata_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bit-banged I2C master against i2c_slave_regs with strobe scoreboards.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_out, sda_oen, wr_en, rd_en, busy;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] mem [256];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];

  always #5 clk = ~clk;

  assign sda_line = sda_oen ? sda_out : sda_m;

  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_out(sda_out), .sda_oen(sda_oen), .reg_addr(reg_addr),
    .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
    .rd_data(rd_data), .busy(busy)
  );

  // synchronous-read register file
  always @(posedge clk) if (rd_en) rd_data <= mem[reg_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && wr_en) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) chk("wr_strobe", {reg_addr, wr_data}, wq.pop_front());
    end
    if (reset === 1'b1 && rd_en) begin
      chk("rd_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) chk("rd_strobe", reg_addr, rq.pop_front());
      chk("rd_wr_exclusive", wr_en, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_c();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0;
  endtask

  task automatic stop_c();
    scl_m = 1'b0; sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic bit_c(input logic b, output logic s);
    #Q; sda_m = b;
    #Q; scl_m = 1'b1;
    #Q; s = sda_line;
    #Q; scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_c(d[i], s);
    bit_c(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_c(1'b1, s);
      d[i] = s;
    end
    bit_c(mack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h3C;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {sda_oen, wr_en, rd_en, busy, reg_addr, wr_data}, 32'd0);
    reset = 1'b1;
    #(2*Q);

    // plain write with auto-increment
    wq.push_back({8'h10, 8'hA5});
    wq.push_back({8'h11, 8'h5A});
    start_c();
    send_byte(8'h84, ack); chk("t1_dev_ack", ack, 1'b0);
    chk("t1_busy", busy, 1'b1);
    send_byte(8'h10, ack); chk("t1_reg_ack", ack, 1'b0);
    send_byte(8'hA5, ack); chk("t1_d0_ack", ack, 1'b0);
    send_byte(8'h5A, ack); chk("t1_d1_ack", ack, 1'b0);
    stop_c();
    chk("t1_busy_after_stop", busy, 1'b0);
    chk("t1_reg_addr", reg_addr, 8'h12);

    // write register pointer, repeated START, read two bytes
    rq.push_back(8'h20);
    rq.push_back(8'h21);
    start_c();
    send_byte(8'h84, ack); chk("t2_dev_ack", ack, 1'b0);
    send_byte(8'h20, ack); chk("t2_reg_ack", ack, 1'b0);
    start_c();
    send_byte(8'h85, ack); chk("t2_rd_dev_ack", ack, 1'b0);
    recv_byte(1'b0, d); chk("t2_rd0", d, 8'hC3);
    recv_byte(1'b1, d); chk("t2_rd1", d, 8'h3C);
    #Q;
    chk("t2_released", sda_oen, 1'b0);
    chk("t2_busy_after_nack", busy, 1'b0);
    stop_c();

    // wrong address: no ACK, no strobes, not busy
    start_c();
    send_byte(8'h86, ack); chk("t3_nack", ack, 1'b1);
    chk("t3_busy", busy, 1'b0);
    send_byte(8'h55, ack); chk("t3_ignored", ack, 1'b1);
    chk("t3_busy2", busy, 1'b0);
    stop_c();

    // register address wraps
    wq.push_back({8'hFF, 8'h11});
    wq.push_back({8'h00, 8'h22});
    start_c();
    send_byte(8'h84, ack); chk("t4_dev_ack", ack, 1'b0);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); chk("t4_d0_ack", ack, 1'b0);
    send_byte(8'h22, ack); chk("t4_d1_ack", ack, 1'b0);
    stop_c();
    chk("t4_reg_addr_wrapped", reg_addr, 8'h01);

    // STOP mid-byte discards the partial data
    start_c();
    send_byte(8'h84, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 5; i++) bit_c(1'b1, s);
    stop_c();
    chk("t5_oen", sda_oen, 1'b0);
    chk("t5_busy", busy, 1'b0);
    wq.push_back({8'h31, 8'h77});
    start_c();
    send_byte(8'h84, ack); chk("t5_next_dev_ack", ack, 1'b0);
    send_byte(8'h31, ack);
    send_byte(8'h77, ack); chk("t5_next_d_ack", ack, 1'b0);
    stop_c();

    // asynchronous reset while the ACK is being driven
    start_c();
    for (int i = 7; i >= 0; i--) bit_c(d[i] & 1'b0 | 8'h84 >> i & 1'b1, s);
    #Q; sda_m = 1'b1; #Q;
    chk("t6_ack_driven", sda_oen, 1'b1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_async_release", sda_oen, 1'b0);
    chk("t6_busy_reset", busy, 1'b0);
    #Q;
    reset = 1'b1;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0;
    send_byte(8'h84, ack); chk("t6_no_start_ignored", ack, 1'b1);
    chk("t6_busy_idle", busy, 1'b0);
    stop_c();
    wq.push_back({8'h40, 8'h99});
    start_c();
    send_byte(8'h84, ack); chk("t6_fresh_dev_ack", ack, 1'b0);
    send_byte(8'h40, ack);
    send_byte(8'h99, ack); chk("t6_fresh_d_ack", ack, 1'b0);
    stop_c();

    #(4*Q);
    chk("wr_queue_drained", wq.size(), 32'd0);
    chk("rd_queue_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
